// File: rtl/shift_regfile_pkg.sv
// Shared definitions for param_shift_regfile: shift-mode codes and the shifter FSM state type.
package shift_regfile_pkg;

    localparam logic [1:0] MODE_LSH = 2'b00;
    localparam logic [1:0] MODE_RSH = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sh_state_t;

endpackage

// File: rtl/param_shift_regfile_shift_step.sv
// One-bit shift/rotate step for the register-file shifter.
// ROR exists only when SHIFT_REGFILE_ROTATE_EN is defined; otherwise mode 11 leaves the value and flag alone.
module shift_step
    import shift_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] next_value,
    output logic                  out_bit,
    output logic                  flag_en
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        flag_en    = 1'b1;
        case (mode)
            MODE_LSH: begin
                next_value = {value[DATA_WIDTH-2:0], 1'b0};
                out_bit    = value[DATA_WIDTH-1];
            end
            MODE_RSH: begin
                next_value = {1'b0, value[DATA_WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ASR: begin
                next_value = {value[DATA_WIDTH-1], value[DATA_WIDTH-1:1]};
                out_bit    = value[0];
            end
            default: begin
`ifdef SHIFT_REGFILE_ROTATE_EN
                next_value = {value[0], value[DATA_WIDTH-1:1]};
                out_bit    = value[0];
`else
                // Rotation compiled out: step is a no-op that leaves the flag untouched.
                next_value = value;
                out_bit    = 1'b0;
                flag_en    = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/param_shift_regfile.sv
// Register file with two combinational read ports, one write port and an in-place multi-cycle shifter.
// Optional rotate mode enabled by defining SHIFT_REGFILE_ROTATE_EN.
module param_shift_regfile
    import shift_regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 4,
    parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_a,
    output logic [DATA_WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_b,
    output logic [DATA_WIDTH-1:0]  rd_data_b,
    input  logic                   sh_start,
    input  logic [ADDR_WIDTH-1:0]  sh_addr,
    input  logic [1:0]             sh_mode,
    input  logic [SHAMT_WIDTH-1:0] sh_amount,
    output logic                   sh_busy,
    output logic                   sh_done,
    output logic                   flag
);

    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];
    sh_state_t              state, state_next;
    logic [ADDR_WIDTH-1:0]  tgt_addr;
    logic [1:0]             tgt_mode;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic [SHAMT_WIDTH-1:0] amt_sat;
    logic [DATA_WIDTH-1:0]  step_value;
    logic                   step_out;
    logic                   step_flag_en;
    logic                   stepping;
    logic                   start_ok;

    assign stepping  = (state == SHIFT);
    assign start_ok  = (state == IDLE) && sh_start;
    assign amt_sat   = (sh_amount > SHAMT_WIDTH'(DATA_WIDTH)) ? SHAMT_WIDTH'(DATA_WIDTH) : sh_amount;
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .value      (regs[tgt_addr]),
        .mode       (tgt_mode),
        .next_value (step_value),
        .out_bit    (step_out),
        .flag_en    (step_flag_en)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sh_start) state_next = (amt_sat == '0) ? DONE : SHIFT;
            SHIFT:   if (cnt == SHAMT_WIDTH'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sh_busy = (state != IDLE);
        sh_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_addr <= '0;
            tgt_mode <= MODE_LSH;
            cnt      <= '0;
            flag     <= 1'b0;
        end else begin
            if (start_ok) begin
                tgt_addr <= sh_addr;
                tgt_mode <= sh_mode;
                cnt      <= amt_sat;
            end else if (stepping) begin
                cnt <= cnt - SHAMT_WIDTH'(1);
            end
            if (stepping && step_flag_en) flag <= step_out;
        end
    end

    // The shift target is locked against writes while it is being stepped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (stepping) regs[tgt_addr] <= step_value;
            if (wr_en && !(stepping && wr_addr == tgt_addr)) regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_param_shift_regfile.sv
// Bench for param_shift_regfile: timeline-based model plus directed vectors with literal expectations.
// Honours SHIFT_REGFILE_ROTATE_EN for the ROR expectations.
module tb_param_shift_regfile;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [W-1:0]  rd_data_a;
    logic [AW-1:0] rd_addr_b = '0;
    logic [W-1:0]  rd_data_b;
    logic          sh_start = 1'b0;
    logic [AW-1:0] sh_addr = '0;
    logic [1:0]    sh_mode = '0;
    logic [SW-1:0] sh_amount = '0;
    logic          sh_busy;
    logic          sh_done;
    logic          flag;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    param_shift_regfile dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .sh_start(sh_start), .sh_addr(sh_addr), .sh_mode(sh_mode), .sh_amount(sh_amount),
        .sh_busy(sh_busy), .sh_done(sh_done), .flag(flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: a shift started after edge s with amount k is busy after edges s..s+k,
    // done after edge s+k, and steps the target on edges s+1..s+k.
    logic [W-1:0] mreg [N];
    logic         mflag;
    int           ecount = 0;
    int           s_start = -1;
    int           s_k = 0;
    int           s_addr = 0;
    int           s_mode = 0;

    function automatic bit exp_busy();
        return (s_start >= 0) && (ecount <= s_start + s_k);
    endfunction

    function automatic bit exp_done();
        return (s_start >= 0) && (ecount == s_start + s_k);
    endfunction

    initial begin
        bit busy_prev, step_now;
        int r;
        for (int i = 0; i < N; i++) mreg[i] = '0;
        mflag = 1'b0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < N; i++) mreg[i] = '0;
                mflag   = 1'b0;
                s_start = -1;
            end else begin
                ecount++;
                busy_prev = (s_start >= 0) && (ecount - 1 <= s_start + s_k);
                step_now  = busy_prev && (ecount <= s_start + s_k);
                if (step_now) begin
                    r = int'(mreg[s_addr]);
                    case (s_mode)
                        0: begin mflag = r[W-1]; mreg[s_addr] = W'(r * 2); end
                        1: begin mflag = r[0];   mreg[s_addr] = W'(r / 2); end
                        2: begin mflag = r[0];   mreg[s_addr] = W'(r / 2 + (r & 8'h80)); end
                        default: begin
`ifdef SHIFT_REGFILE_ROTATE_EN
                            mflag = r[0]; mreg[s_addr] = W'(r / 2 + (r % 2) * 128);
`endif
                        end
                    endcase
                end
                if (wr_en && !(step_now && int'(wr_addr) == s_addr)) mreg[wr_addr] = wr_data;
                if (!busy_prev && sh_start) begin
                    s_start = ecount;
                    s_k     = (int'(sh_amount) > W) ? W : int'(sh_amount);
                    s_addr  = int'(sh_addr);
                    s_mode  = int'(sh_mode);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rd_a", rd_data_a, mreg[rd_addr_a]);
            check("model_rd_b", rd_data_b, mreg[rd_addr_b]);
            check("model_busy", sh_busy, exp_busy());
            check("model_done", sh_done, exp_done());
            check("model_flag", flag, mflag);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start(input int a, input logic [1:0] m, input int amt);
        sh_start = 1'b1; sh_addr = AW'(a); sh_mode = m; sh_amount = SW'(amt);
        tick();
        sh_start = 1'b0;
    endtask

    task automatic read_a(input string name, input int a, input logic [W-1:0] exp);
        rd_addr_a = AW'(a);
        #1;
        check(name, rd_data_a, exp);
    endtask

    // Counts post-edge samples with busy / done high until idle; bounded.
    task automatic run_idle(output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        while (sh_busy && busy_n < 40) begin
            busy_n++;
            if (sh_done) done_n++;
            tick();
        end
        if (busy_n >= 40) check("idle_timeout", 1, 0);
    endtask

    initial begin
        int b, d;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        tick();
        read_a("rst_reg0", 0, 8'h00);
        check("rst_busy", sh_busy, 1'b0);
        check("rst_flag", flag, 1'b0);

        // Reset in the middle of a shift
        wr(1, 8'hA5);
        start(1, 2'b00, 3);
        tick(); tick();
        reset = 1'b1;
        #1;
        read_a("midrst_reg1", 1, 8'h00);
        check("midrst_flag", flag, 1'b0);
        check("midrst_busy", sh_busy, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_nodone", sh_done, 1'b0);

        // LSH by 1
        wr(2, 8'h81);
        start(2, 2'b00, 1);
        rd_addr_b = 2'd2;
        run_idle(b, d);
        read_a("lsh_reg2", 2, 8'h02);
        check("lsh_flag", flag, 1'b1);
        check("lsh_busy_cycles", b, 2);
        check("lsh_done_cycles", d, 1);

        // ASR vs RSH
        wr(0, 8'h90);
        start(0, 2'b10, 3);
        run_idle(b, d);
        read_a("asr_reg0", 0, 8'hF2);
        check("asr_flag", flag, 1'b0);
        wr(0, 8'h90);
        start(0, 2'b01, 5);
        run_idle(b, d);
        read_a("rsh_reg0", 0, 8'h04);
        check("rsh_flag", flag, 1'b1);

        // Zero amount
        wr(3, 8'h3C);
        start(3, 2'b01, 0);
        check("zero_done_now", sh_done, 1'b1);
        run_idle(b, d);
        read_a("zero_reg3", 3, 8'h3C);
        check("zero_flag", flag, 1'b1);
        check("zero_busy_cycles", b, 1);

        // Saturated amount
        wr(1, 8'hFF);
        start(1, 2'b01, 15);
        run_idle(b, d);
        read_a("sat_reg1", 1, 8'h00);
        check("sat_flag", flag, 1'b1);
        check("sat_busy_cycles", b, 9);

        // Collisions during SHIFT
        wr(0, 8'h0F);
        start(0, 2'b00, 4);
        tick();
        wr(0, 8'h11);
        wr(2, 8'h22);
        start(1, 2'b01, 2);
        run_idle(b, d);
        read_a("coll_reg0", 0, 8'hF0);
        read_a("coll_reg2", 2, 8'h22);
        tick();
        check("coll_ignored_start", sh_busy, 1'b0);

        // Write and start on the same edge, same register
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h40;
        start(3, 2'b00, 1);
        wr_en = 1'b0;
        run_idle(b, d);
        read_a("same_edge_reg3", 3, 8'h80);
        check("same_edge_flag", flag, 1'b0);

        // ROR with the rotate feature on or off
        wr(1, 8'h03);
        start(1, 2'b11, 1);
        run_idle(b, d);
        check("ror_done_cycles", d, 1);
`ifdef SHIFT_REGFILE_ROTATE_EN
        read_a("ror_reg1", 1, 8'h81);
        check("ror_flag", flag, 1'b1);
`else
        read_a("ror_reg1", 1, 8'h03);
        check("ror_flag", flag, 1'b0);
`endif

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
